// File: rtl/event_encoder_pkg.sv
// Shared definitions for the event encoder: output-slot states and the
// lowest-set-bit search used by both the datapath and reference models.
package event_encoder_pkg;

  localparam int unsigned MAX_N = 32;
  localparam int unsigned IDX_W = $clog2(MAX_N);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Scans downward so the lowest set bit is the last one written.
  function automatic logic [IDX_W-1:0] lowest_set_index(input logic [MAX_N-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = MAX_N; i > 0; i--) begin
      if (vec[i-1]) idx = IDX_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_encoder_prio.sv
// Combinational lowest-index-first priority encoder over the pending vector.
module prio_encoder
  import event_encoder_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] reqIn,
  output logic [W-1:0] idxOut,
  output logic         anyOut
);

  always_comb begin
    idxOut = W'(lowest_set_index(MAX_N'(reqIn)));
    anyOut = |reqIn;
  end

endmodule

// File: rtl/event_encoder.sv
// Captures event pulses as pending bits and delivers their indices, lowest
// first, one per handshake through a registered valid/ready output.
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] eventIn,
  input  logic         readyIn,
  output logic [W-1:0] dataOut,
  output logic         validOut,
  output logic [N-1:0] pendingOut,
  output logic         overrunOut
);

  logic [N-1:0] pending;
  logic [N-1:0] clr;
  logic [W-1:0] data;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         free;
  logic         load;
  logic         overrun;
  slot_state_e  state;

  prio_encoder #(.N(N)) u_prio (
    .reqIn  (pending),
    .idxOut (sel_idx),
    .anyOut (sel_any)
  );

  always_comb begin
    free = (state == SLOT_EMPTY) || readyIn;
    load = free && sel_any;
    clr  = '0;
    if (load) clr[sel_idx] = 1'b1;
  end

  // A bit loaded this edge is cleared before eventIn is OR-ed in, so a
  // coincident re-assertion counts as a fresh event rather than an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      data    <= '0;
      state   <= SLOT_EMPTY;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | eventIn;
      if (|(eventIn & pending & ~clr)) overrun <= 1'b1;
      if (load) begin
        data  <= sel_idx;
        state <= SLOT_FULL;
      end else if (free) begin
        state <= SLOT_EMPTY;
      end
    end
  end

  assign dataOut    = data;
  assign validOut   = (state == SLOT_FULL);
  assign pendingOut = pending;
  assign overrunOut = overrun;

endmodule
